// File: rtl/t05_sram_arb_pkg.sv
// ============================================================================
// Module      : t05_sram_arb_pkg
// Description : Shared types and constants for the t05 SRAM port arbiter.
//               client_t     - requester identities (HIST..TRN)
//               arb_state_t  - arbiter sequencing states
//               WORD_BYTES   - byte stride between burst words
//               SEL_ALL      - byte-enable pattern for a full-word strobe
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package t05_sram_arb_pkg;

    typedef enum logic [2:0] {
        HIST  = 3'd0,
        FLV   = 3'd1,
        HTREE = 3'd2,
        CB    = 3'd3,
        TRN   = 3'd4
    } client_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int         WORD_BYTES = 4;
    localparam logic [3:0] SEL_ALL    = 4'hF;
    localparam int         ID_W       = 3;

endpackage

`default_nettype wire

// File: rtl/t05_rr_picker.sv
// ============================================================================
// Module      : t05_rr_picker
// Description : Combinational round-robin pick. Returns the first asserted
//               request at or after the pointer, wrapping past N_REQ-1.
// Ports       : req   [N_REQ-1:0] in  - request vector
//               ptr   [IDX_W-1:0] in  - starting index (always < N_REQ)
//               grant [N_REQ-1:0] out - one-hot winner (0 if none)
//               idx   [IDX_W-1:0] out - winner index (0 if none)
//               valid             out - some request is asserted
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module t05_rr_picker
    import t05_sram_arb_pkg::*;
#(
    parameter int N_REQ = 5,
    parameter int IDX_W = ID_W
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        int cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!valid && (|((req >> cand) & N_REQ'(1)))) begin
                valid = 1'b1;
                grant = N_REQ'(1) << cand;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/t05_sram_arbiter.sv
// ============================================================================
// Module      : t05_sram_arbiter
// Description : Round-robin sharer of the single t05 SRAM word port among the
//               five Huffman-pipeline clients. Each granted burst (1..4
//               words) is split into single-word strobes; read words are
//               assembled into rdata and a one-cycle done pulse is returned.
// Ports       : clk, nrst (sync, active-low)
//               client_req/we/addr/wdata/len    - per-client burst request
//               client_grant/done, rdata         - per-client response
//               active_id                        - granted index, 0 when idle
//               wr_en/r_en/addr/data_i/select    - SRAM strobe side
//               data_o/busy_o                    - SRAM return side
//               err                              - watchdog abort flag
// Options     : T05_ARB_TIMEOUT_EN - WAIT watchdog of TIMEOUT cycles; on
//               expiry the burst is aborted to DONE and err sticks high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module t05_sram_arbiter
    import t05_sram_arb_pkg::*;
#(
    parameter int N_CLIENTS = 5,
    parameter int MAX_WORDS = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [N_CLIENTS-1:0]          client_req,
    input  logic [N_CLIENTS-1:0]          client_we,
    input  logic [N_CLIENTS*32-1:0]       client_addr,
    input  logic [N_CLIENTS*MAX_WORDS*32-1:0] client_wdata,
    input  logic [N_CLIENTS*2-1:0]        client_len,
    output logic [N_CLIENTS-1:0]          client_grant,
    output logic [N_CLIENTS-1:0]          client_done,
    output logic [MAX_WORDS*32-1:0]       rdata,
    output logic [ID_W-1:0]               active_id,
    output logic                          wr_en,
    output logic                          r_en,
    output logic [31:0]                   addr,
    output logic [31:0]                   data_i,
    output logic [3:0]                    select,
    input  logic [31:0]                   data_o,
    input  logic                          busy_o,
    output logic                          err
);

    localparam int BW = MAX_WORDS * 32;

    arb_state_t             state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [N_CLIENTS-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic                   we_q, we_d;
    logic [31:0]            base_q, base_d;
    logic [1:0]             len_q, len_d;
    logic [BW-1:0]          wdata_q, wdata_d;
    logic [1:0]             k_q, k_d;
    logic [BW-1:0]          rdata_q, rdata_d;

`ifdef T05_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
`endif

    logic [N_CLIENTS-1:0]   pick_grant;
    logic [ID_W-1:0]        pick_idx;
    logic                   pick_valid;

    logic                   sel_we;
    logic [31:0]            sel_addr;
    logic [1:0]             sel_len;
    logic [BW-1:0]          sel_wdata;

    logic                   strobe;

    t05_rr_picker #(
        .N_REQ (N_CLIENTS),
        .IDX_W (ID_W)
    ) u_picker (
        .req   (client_req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Route the winning client's burst descriptor to the capture registers.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_len   = '0;
        sel_wdata = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (pick_grant[i]) begin
                sel_we    = client_we[i];
                sel_addr  = client_addr[i*32 +: 32];
                sel_len   = client_len[i*2 +: 2];
                sel_wdata = client_wdata[i*BW +: BW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        id_d    = id_q;
        we_d    = we_q;
        base_d  = base_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        k_d     = k_q;
        rdata_d = rdata_q;
`ifdef T05_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_grant;
                    id_d    = pick_idx;
                    we_d    = sel_we;
                    base_d  = sel_addr;
                    len_d   = sel_len;
                    wdata_d = sel_wdata;
                    k_d     = '0;
                    rdata_d = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef T05_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (busy_o) begin
`ifdef T05_ARB_TIMEOUT_EN
                    // Words not yet captured stay 0 from the grant-time clear.
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end else begin
                    if (!we_q) begin
                        rdata_d[{k_q, 5'd0} +: 32] = data_o;
                    end
                    if (k_q < len_q) begin
                        k_d     = k_q + 2'd1;
                        state_d = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                grant_d = '0;
                id_d    = '0;
                k_d     = '0;
                ptr_d   = (id_q == ID_W'(N_CLIENTS - 1)) ? '0 : id_q + ID_W'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            id_q    <= '0;
            we_q    <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            k_q     <= '0;
            rdata_q <= '0;
`ifdef T05_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            we_q    <= we_d;
            base_q  <= base_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            k_q     <= k_d;
            rdata_q <= rdata_d;
`ifdef T05_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Strobes are decoded from state so each lasts exactly the ISSUE cycle.
    assign strobe       = (state_q == ISSUE);
    assign r_en         = strobe & ~we_q;
    assign wr_en        = strobe & we_q;
    assign addr         = strobe ? (base_q + 32'(k_q) * 32'(WORD_BYTES)) : 32'd0;
    assign data_i       = strobe ? wdata_q[{k_q, 5'd0} +: 32] : 32'd0;
    assign select       = strobe ? SEL_ALL : 4'h0;
    assign client_grant = grant_q;
    assign client_done  = (state_q == DONE) ? grant_q : '0;
    assign active_id    = id_q;
    assign rdata        = rdata_q;

`ifdef T05_ARB_TIMEOUT_EN
    assign err = err_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^32'(TIMEOUT);
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_t05_sram_arbiter.sv
// ============================================================================
// Module      : tb_t05_sram_arbiter
// Description : Self-checking bench for t05_sram_arbiter. A transaction-level
//               model predicts grant order, strobe contents and returned
//               read data; a per-cycle checker compares the DUT against it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_t05_sram_arbiter;

    localparam int N = 5;

    logic             clk = 1'b0;
    logic             nrst;
    logic [N-1:0]     client_req, client_we;
    logic [N*32-1:0]  client_addr;
    logic [N*128-1:0] client_wdata;
    logic [N*2-1:0]   client_len;
    logic [N-1:0]     client_grant, client_done;
    logic [127:0]     rdata;
    logic [2:0]       active_id;
    logic             wr_en, r_en, err;
    logic [31:0]      addr, data_i;
    logic [3:0]       select;
    logic [31:0]      data_o = 32'd0;
    logic             busy_o = 1'b0;

    always #5 clk = ~clk;

    t05_sram_arbiter #(.N_CLIENTS(N), .MAX_WORDS(4), .TIMEOUT(255)) dut (
        .clk(clk), .nrst(nrst),
        .client_req(client_req), .client_we(client_we),
        .client_addr(client_addr), .client_wdata(client_wdata),
        .client_len(client_len), .client_grant(client_grant),
        .client_done(client_done), .rdata(rdata), .active_id(active_id),
        .wr_en(wr_en), .r_en(r_en), .addr(addr), .data_i(data_i),
        .select(select), .data_o(data_o), .busy_o(busy_o), .err(err)
    );

    typedef struct { int id; logic we; logic [31:0] addr; logic [31:0] data; } strobe_t;
    typedef struct { int id; logic [127:0] rdata; bit tmo; } done_t;

    strobe_t     exp_s[$];
    done_t       exp_d[$];
    logic [31:0] rsp_q[$];
    int          done_log[$];
    int          done_cyc[$];

    int          n_vec = 0, n_fail = 0;
    int          cyc = 0;
    int          busy_cycles = 0;
    bit          stuck = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] last_addr = 32'd0;
    int          t0;

    // model: per-client staged burst and round-robin pointer
    logic        m_we[N];
    logic [31:0] m_addr[N];
    int          m_len[N];
    logic [31:0] m_wd[N][4];
    int          m_ptr = 0;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic miss(string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: got event expected none", name);
    endtask

    function automatic bit bitv(logic [N-1:0] v, int i);
        return ((v >> i) & N'(1)) != '0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM responder: busy for busy_cycles WAIT cycles after each strobe.
    int bcnt = 0;
    always @(negedge clk) begin
        if (r_en || wr_en) begin
            bcnt   = busy_cycles;
            busy_o = stuck || (bcnt > 0);
            if (r_en) data_o = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'd0;
        end else begin
            busy_o = stuck || (bcnt > 0);
            if (bcnt > 0) bcnt--;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        strobe_t s;
        done_t   d;
        int      exp_id;
        if (!nrst) begin
            exp_err = 1'b0;
        end else begin
            chk("select", select, (r_en || wr_en) ? 4'hF : 4'h0);
            if (r_en || wr_en) begin
                if (exp_s.size() == 0) miss("unexpected_strobe");
                else begin
                    s = exp_s.pop_front();
                    chk("strobe_we", wr_en, s.we);
                    chk("strobe_re", r_en, !s.we);
                    chk("strobe_addr", addr, s.addr);
                    chk("strobe_grant", client_grant, 128'd1 << s.id);
                    if (s.we) chk("strobe_data", data_i, s.data);
                end
                last_addr = addr;
            end
            chk("grant_onehot", $onehot0(client_grant), 1);
            exp_id = 0;
            for (int i = 0; i < N; i++) if (bitv(client_grant, i)) exp_id = i;
            chk("active_id", active_id, exp_id);
            if (client_done != '0) begin
                if (exp_d.size() == 0) miss("unexpected_done");
                else begin
                    d = exp_d.pop_front();
                    chk("done_vec", client_done, 128'd1 << d.id);
                    chk("done_rdata", rdata, d.rdata);
                    if (d.tmo) exp_err = 1'b1;
                    done_log.push_back(d.id);
                    done_cyc.push_back(cyc);
                end
            end
            chk("err", err, exp_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic stage(int id, bit we, logic [31:0] a, int len,
                         logic [31:0] w0, logic [31:0] w1, logic [31:0] w2, logic [31:0] w3);
        m_we[id] = we; m_addr[id] = a; m_len[id] = len;
        m_wd[id][0] = w0; m_wd[id][1] = w1; m_wd[id][2] = w2; m_wd[id][3] = w3;
        client_we[id]              = we;
        client_addr[id*32 +: 32]   = a;
        client_len[id*2 +: 2]      = 2'(len);
        client_wdata[id*128 +: 128] = {w3, w2, w1, w0};
    endtask

    // Expected strobes and completion of one full burst.
    task automatic enqueue(int id);
        logic [127:0] rd;
        strobe_t      s;
        done_t        d;
        rd = '0;
        for (int k = 0; k <= m_len[id]; k++) begin
            s.id = id; s.we = m_we[id];
            s.addr = m_addr[id] + 32'(4 * k);
            s.data = m_wd[id][k];
            exp_s.push_back(s);
            if (!m_we[id]) begin
                rsp_q.push_back(m_wd[id][k]);
                rd[k*32 +: 32] = m_wd[id][k];
            end
        end
        d.id = id; d.rdata = rd; d.tmo = 1'b0;
        exp_d.push_back(d);
    endtask

    // Requests raised together while idle are served in round-robin order.
    task automatic launch(logic [N-1:0] mask);
        logic [N-1:0] pend;
        int           p, pick, c;
        pend = mask;
        p    = m_ptr;
        while (pend != '0) begin
            pick = -1;
            for (int i = 0; i < N; i++) begin
                c = (p + i) % N;
                if (pick < 0 && bitv(pend, c)) pick = c;
            end
            pend = pend & ~(N'(1) << pick);
            p    = (pick + 1) % N;
            enqueue(pick);
        end
        m_ptr      = p;
        client_req = client_req | mask;
    endtask

    task automatic launch_tmo(int id);
        strobe_t s;
        done_t   d;
        s.id = id; s.we = m_we[id]; s.addr = m_addr[id]; s.data = m_wd[id][0];
        exp_s.push_back(s);
        d.id = id; d.rdata = '0; d.tmo = 1'b1;
        exp_d.push_back(d);
        m_ptr      = (id + 1) % N;
        client_req = client_req | (N'(1) << id);
    endtask

    task automatic run(int budget);
        int t;
        t = 0;
        while ((exp_d.size() != 0 || exp_s.size() != 0) && t < budget) begin
            tick();
            t++;
            client_req = client_req & ~client_done;
        end
        chk("drain_done", exp_d.size(), 0);
        chk("drain_strobe", exp_s.size(), 0);
    endtask

    task automatic flush_model();
        exp_s.delete(); exp_d.delete(); rsp_q.delete();
        client_req = '0;
        m_ptr      = 0;
    endtask

    task automatic clear_log();
        done_log.delete(); done_cyc.delete();
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_grant"}, client_grant, 0);
        chk({tag, "_done"}, client_done, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_id"}, active_id, 0);
        chk({tag, "_strobes"}, {wr_en, r_en, err}, 0);
        chk({tag, "_addr"}, addr, 0);
        chk({tag, "_data_i"}, data_i, 0);
        chk({tag, "_select"}, select, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        nrst = 1'b0; client_req = '0; client_we = '0; client_addr = '0;
        client_wdata = '0; client_len = '0;
        repeat (3) tick();
        check_zero("reset");
        nrst = 1'b1;
        tick();

        // single-word read, busy 2 cycles
        busy_cycles = 2;
        stage(0, 1'b0, 32'h40, 0, 32'd25, 0, 0, 0);
        clear_log(); t0 = cyc;
        launch(5'b00001);
        run(50);
        chk("t1_rdata", rdata, 128'd25);
        chk("t1_ndone", done_log.size(), 1);
        if (done_cyc.size() > 0) chk("t1_latency", done_cyc[0] - t0, 5);

        // HTREE 3-word write
        busy_cycles = 1;
        stage(2, 1'b1, 32'h100, 2, 32'd44, 32'd76, 32'd6, 0);
        clear_log();
        launch(5'b00100);
        run(60);
        chk("t2_last_addr", last_addr, 32'h108);
        chk("t2_ndone", done_log.size(), 1);

        // CB 4-word read
        stage(3, 1'b0, 32'h300, 3, 32'd17, 32'd73, 32'd144, 32'd338);
        launch(5'b01000);
        run(80);
        chk("t3_rdata", rdata, 128'h00000152_00000090_00000049_00000011);

        // contention straight after reset
        nrst = 1'b0; flush_model(); tick(); nrst = 1'b1; tick();
        busy_cycles = 0;
        for (int i = 0; i < N; i++) stage(i, 1'b0, 32'h1000 + 32'(16 * i), 0, 32'(100 + i), 0, 0, 0);
        clear_log(); t0 = cyc;
        launch(5'b11111);
        run(100);
        chk("t4_ndone", done_log.size(), 5);
        if (done_log.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("t4_order", done_log[i], i);
            chk("t4_latency", done_cyc[0] - t0, 3);
        end
        stage(1, 1'b1, 32'h2000, 0, 32'hAAAA_5555, 0, 0, 0);
        stage(4, 1'b0, 32'h2400, 1, 32'h0BAD_F00D, 32'h1234_5678, 0, 0);
        clear_log();
        launch(5'b10010);
        run(60);
        chk("t5_ndone", done_log.size(), 2);
        if (done_log.size() == 2) begin
            chk("t5_first", done_log[0], 1);
            chk("t5_second", done_log[1], 4);
        end

        // reset during WAIT of word 1 of a 3-word burst
        stage(1, 1'b1, 32'h500, 0, 32'd5, 0, 0, 0);
        launch(5'b00010);
        run(30);
        busy_cycles = 1;
        stage(2, 1'b1, 32'h600, 2, 32'd7, 32'd8, 32'd9, 0);
        clear_log();
        launch(5'b00100);
        repeat (5) tick();
        chk("t6_mid_wait", {client_grant, wr_en}, {5'b00100, 1'b0});
        nrst = 1'b0;
        flush_model();
        tick();
        check_zero("midrst");
        chk("t6_no_done", done_log.size(), 0);
        nrst = 1'b1;
        stage(1, 1'b0, 32'h700, 0, 32'd61, 0, 0, 0);
        stage(3, 1'b0, 32'h800, 0, 32'd62, 0, 0, 0);
        clear_log();
        launch(5'b01010);
        run(60);
        if (done_log.size() > 0) chk("t6_ptr_reset", done_log[0], 1);
        else miss("t6_ptr_reset_missing");

        // address wrap
        busy_cycles = 0;
        stage(4, 1'b1, 32'hFFFF_FFFC, 1, 32'h11, 32'h22, 0, 0);
        launch(5'b10000);
        run(40);
        chk("t7_wrap_addr", last_addr, 32'h0000_0000);

`ifdef T05_ARB_TIMEOUT_EN
        stage(0, 1'b0, 32'h200, 1, 32'd5, 32'd6, 0, 0);
        stuck = 1'b1;
        clear_log(); t0 = cyc;
        launch_tmo(0);
        run(400);
        stuck = 1'b0;
        chk("t8_err", err, 1);
        if (done_cyc.size() > 0) chk("t8_latency", done_cyc[0] - t0, 257);
        else miss("t8_no_done");
`endif

        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/t05_sram_arbiter.md
Name: t05_sram_arbiter

Overview:
Sequences and shares the single t05 SRAM word port between the five Huffman-pipeline clients: histogram, find-least-value, htree, codebook and translation. Each client posts a burst of 1–4 32-bit words, either read or write. The block grants one client at a time in round-robin order and splits the burst into single-word strobes on the SRAM port. It returns assembled read data and a one-cycle done pulse to the granted client. It sits between the pipeline FSMs and the SRAM wishbone-side interface.

Parameters:
N_CLIENTS, 5, number of requesters; index 0=HIST, 1=FLV, 2=HTREE, 3=CB, 4=TRN.
MAX_WORDS, 4, maximum burst length in 32-bit words.
TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
clk  in  1  system clock
nrst  in  1  synchronous active-low reset
client_req  in  N_CLIENTS  per-client request; must be held until that client's done
client_we  in  N_CLIENTS  1 = write burst, 0 = read burst
client_addr  in  N_CLIENTS*32  byte base address, slice i belongs to client i
client_wdata  in  N_CLIENTS*128  write data; word k = bits [32k+31:32k]
client_len  in  N_CLIENTS*2  burst length minus 1 (0 → 1 word, 3 → 4 words)
client_grant  out  N_CLIENTS  one-hot; high for the whole granted burst
client_done  out  N_CLIENTS  one-cycle pulse when the burst completes
rdata  out  128  assembled read data; valid when done pulses; unused words = 0
active_id  out  3  index of the granted client; 0 when idle
wr_en  out  1  one-cycle SRAM write strobe
r_en  out  1  one-cycle SRAM read strobe
addr  out  32  SRAM byte address
data_i  out  32  SRAM write word
select  out  4  byte enables; 4'hF whenever a strobe is active, else 0
data_o  in  32  SRAM read word
busy_o  in  1  SRAM transaction in progress
err  out  1  watchdog abort flag (optional feature only; otherwise tied 0)

Behaviour:
- Reset (nrst=0 at a clk edge): every output = 0, state = IDLE, round-robin pointer = 0, word counter = 0. Reset mid-burst abandons the burst with no done pulse.
- States:
  - IDLE: if any client_req is high, pick the first requester at or after the pointer (wrapping), register grant, active_id, we, addr, len and wdata, go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive r_en or wr_en high for exactly one cycle with addr = base + 4k (32-bit add, wraps mod 2^32) and data_i = word k. Go to WAIT.
  - WAIT: stay while busy_o = 1. busy_o is not sampled in the same cycle as the strobe. When busy_o = 0: on a read, capture data_o into rdata word k. Then if k < len, increment k and go to ISSUE; else go to DONE.
  - DONE: pulse client_done[id] for one cycle, drop grant, set pointer = id+1 mod N_CLIENTS, go to IDLE.
- Minimum single-word latency: req seen at edge 0 → strobe cycle 1 → WAIT cycle 2 → done cycle 3.
- rdata is cleared at grant and holds its value after done until the next grant.
- Simultaneous requests: resolved by the round-robin pointer only; no client wins twice while another is waiting.
- A request dropped mid-burst is ignored; the burst runs to completion.
- Requests arriving during a burst are queued implicitly by their held req lines.

Optional Feature:
T05_ARB_TIMEOUT_EN.
- Defined: a cycle counter runs in WAIT and clears on every strobe. If it reaches TIMEOUT, the arbiter aborts to DONE: done still pulses, err is set sticky high until reset, and rdata words not yet captured read 0.
- Undefined: no counter; WAIT waits forever; err is tied 0.

Decomposition:
- Package t05_sram_arb_pkg holds:
  - client_t enum (HIST, FLV, HTREE, CB, TRN);
  - arb_state_t enum (IDLE, ISSUE, WAIT, DONE);
  - constants WORD_BYTES=4 and SEL_ALL=4'hF.
- One sub-module, t05_rr_picker: combinational round-robin pick of (req vector, pointer) → one-hot grant plus index.

Test Plan:
- Single read: HIST req, addr 0x40, len 0; busy_o high for 2 cycles after the strobe, data_o = 25 → one r_en at addr 0x40; done[0] pulses; rdata = 25.
- HTREE 3-word write: addr 0x100, wdata words {44, 76, 6}, len 2, busy_o high 1 cycle per word → wr_en at addresses 0x100, 0x104, 0x108 carrying 44, 76, 6; select = F on each strobe; exactly one done[2] pulse.
- CB 4-word read: data_o returns 17, 73, 144, 338 → rdata = {338, 144, 73, 17} (word 0 in the LSBs); done[3] pulses.
- Contention: all five clients request together after reset, 1 word each → grant order 0, 1, 2, 3, 4. Then FLV and TRN re-request while the pointer is at 0 → FLV is granted before TRN.
- Reset mid-burst: nrst low during WAIT of word 1 of a 3-word burst → next cycle all outputs 0 and state IDLE; no done pulse; pointer back to 0.
- Address wrap / timeout: base 0xFFFFFFFC, len 1 → second strobe at addr 0x00000000. With T05_ARB_TIMEOUT_EN and busy_o stuck high → abort after 255 cycles; err = 1; done pulses.
